// File: rtl/data_mem_unit_if.sv
// Request/response bus between the EX-side requester and the MA data memory.
// The master issues loads/stores; the slave (data_mem_unit) answers one at a time.
interface data_mem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/data_mem_unit.sv
// Word-organised little-endian data memory for the MA stage: byte/half/word
// loads and stores with extension, alignment checking and a post-reset clear sweep.
module data_mem_unit #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_unit_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              init_done_q, init_done_d;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [4:0]        shamt;
    logic              acc_err;
    logic [31:0]       old_word;
    logic [31:0]       lane_data;
    logic [31:0]       ld_val;
    logic [3:0]        be;
    logic [3:0]        be_sh;
    logic [31:0]       wmask;
    logic [31:0]       st_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // High address bits alias by design.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    // Access datapath: read-modify-write on the addressed word.
    always_comb begin
        idx       = bus.req_addr[ADDR_W+1:2];
        lane      = bus.req_addr[1:0];
        shamt     = {lane, 3'b000};
        acc_err   = (bus.req_size == 2'b11) ||
                    (bus.req_size == 2'b01 && lane[0]) ||
                    (bus.req_size == 2'b10 && lane != 2'b00);
        old_word  = mem[idx];
        lane_data = old_word >> shamt;
        case (bus.req_size)
            2'b00:   ld_val = {{24{bus.req_signed & lane_data[7]}}, lane_data[7:0]};
            2'b01:   ld_val = {{16{bus.req_signed & lane_data[15]}}, lane_data[15:0]};
            default: ld_val = old_word;
        endcase
        case (bus.req_size)
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        be_sh   = be << lane;
        wmask   = {{8{be_sh[3]}}, {8{be_sh[2]}}, {8{be_sh[1]}}, {8{be_sh[0]}}};
        st_word = (old_word & ~wmask) | ((bus.req_wdata << shamt) & wmask);
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_wdata   = st_word;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (bus.req_valid) begin
                    state_d     = RESP;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || bus.req_we) ? 32'h0 : ld_val;
                    mem_we      = bus.req_we && !acc_err;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // No array reset: the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            clr_cnt_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit against a byte-array memory model,
// plus the directed init / sub-word / error / back-pressure / reset scenarios.
module tb_data_mem_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0] mb [4096];

    data_mem_unit_if bus ();
    data_mem_unit #(.ADDR_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: address taken mod 4096 bytes.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e);
        int base, n;
        logic [31:0] v;
        base = int'(a[11:0]);
        n    = 1 << sz;
        e    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd   = 32'h0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8*i));
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endtask

    task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] got);
        logic [31:0] exp_d;
        logic        exp_e;
        int          w;
        model(we, sz, sg, a, wd, exp_d, exp_e);
        @(negedge clk);
        bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 32'(bus.req_ready), 32'h1);
            bus.req_valid = 1'b0;
            got = 32'h0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr = $urandom;
        chk("rsp_latency", 32'(bus.rsp_valid), 32'h1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'h1);
            chk("hold_ready", 32'(bus.req_ready), 32'h0);
            chk("hold_rdata", bus.rsp_rdata, exp_d);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        chk("rdata", bus.rsp_rdata, exp_d);
        chk("err", 32'(bus.rsp_err), 32'(exp_e));
        got = bus.rsp_rdata;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'h0);
        chk("ready_back", 32'(bus.req_ready), 32'h1);
    endtask

    task automatic wait_init();
        int cnt = 0;
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        while (cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.req_ready) break;
        end
        chk("init_cycles", 32'(cnt), 32'd1024);
        chk("init_done", 32'(bus.init_done), 32'h1);
    endtask

    initial begin
        logic [31:0] g;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_init_done", 32'(bus.init_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_init();

        access(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0, g);
        chk("plan_init_load", g, 32'h0);
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, g);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("plan_word", g, 32'hDEADBEEF);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, g);
        chk("plan_b13s", g, 32'hFFFFFFDE);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, g);
        chk("plan_b13u", g, 32'h000000DE);
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, g);
        chk("plan_h12s", g, 32'hFFFFDEAD);
        access(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, g);
        chk("plan_b10s", g, 32'hFFFFFFEF);
        access(1'b1, 2'd1, 1'b0, 32'h12, 32'hAAAA1234, 0, g);
        access(1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFFFF55, 0, g);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("plan_partial", g, 32'h1234BE55);
        access(1'b1, 2'd3, 1'b0, 32'h11, 32'hCAFEF00D, 0, g);
        access(1'b1, 2'd2, 1'b0, 32'h11, 32'hCAFEF00D, 0, g);
        access(1'b1, 2'd1, 1'b0, 32'h13, 32'hCAFEF00D, 0, g);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("plan_err_nowrite", g, 32'h1234BE55);
        access(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 0, g);
        chk("plan_alias", g, 32'h1234BE55);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, g);

        for (int k = 0; k < 250; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 2)), g);
        end

        // Reset while a response is pending.
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rr_resp", 32'(bus.rsp_valid), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rr_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rr_ready", 32'(bus.req_ready), 32'h0);
        chk("rr_init_done", 32'(bus.init_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_init();
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("rr_cleared", g, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised, handshaked data-memory stage for the memory-access (MA) step of the SimpleRisc datapath. It holds a word-organised RAM of 2^ADDR_W 32-bit words and serves byte, halfword and word loads and stores with sign or zero extension. It flags misaligned or illegal accesses and clears the whole array after reset through a sequential init sweep. It sits between the ALU/EX stage (address from aluResult, store data from op2) and the writeback stage (ldResult).

## Interface

- ADDR_W, default 10, log2 of the memory depth in 32-bit words (depth = 2^ADDR_W); data width is fixed at 32.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  load extension: 1 sign-extend, 0 zero-extend; ignored for word loads and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or illegal.
- init_done  out  1  post-reset clear sweep has finished.

## Operation

- States: INIT, IDLE, RESP.
- INIT:
  - Writes 0 to word clr_cnt and increments clr_cnt from 0 to 2^ADDR_W-1.
  - On the last word, moves to IDLE and sets init_done.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, performs the access and moves to RESP.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - On rsp_ready, moves to IDLE.
- Address decode: word index = req_addr[ADDR_W+1:2]; lane = req_addr[1:0]. Bits [31:ADDR_W+2] are ignored, so addresses alias modulo 2^(ADDR_W+2).
- Memory is little-endian: lane 0 holds bits [7:0].
- Error conditions:
  - req_size=11.
  - Halfword with lane[0]=1.
  - Word with lane!=0.
- On an error: no memory write, rsp_err=1, rsp_rdata=0.
- Byte store writes req_wdata[7:0] into the selected lane. Other lanes are untouched.
- Halfword store writes req_wdata[15:0] into lanes lane and lane+1. Other lanes are untouched.
- Word store writes all four lanes.
- Store response: rsp_rdata=0, rsp_err=0.
- Byte load returns the selected lane, extended to 32 bits per req_signed.
- Halfword load returns lanes lane+1:lane, extended per req_signed.
- Word load returns the full word.
- Accesses are strictly in order, one outstanding at a time. A load after a store to the same address returns the stored data.

## Timing

- Reset (synchronous) values:
  - state=INIT, clr_cnt=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- INIT lasts exactly 2^ADDR_W cycles after reset deasserts.
  - init_done=1 and req_ready=1 from the following cycle.
  - init_done stays 1 until the next reset.
- req_ready and rsp_valid are decoded from the state register only; there is no combinational path from req_valid or rsp_ready.
- Access edge: the store write and the registering of read data happen on the accepting posedge.
  - rsp_valid rises in the next cycle (latency 1).
- Response hold: rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- Throughput: at most one request every 2 cycles. Response handshake at edge N means a new request can be accepted at edge N+1.
- req_valid during INIT or RESP is ignored; the requester must hold it.
- Reset asserted in any state, including mid-INIT or RESP:
  - Any pending response is discarded; rsp_valid=0 the next cycle.
  - The clear sweep restarts from word 0.

## Test plan

- Init: ADDR_W=10, deassert reset → req_ready=0 for exactly 1024 cycles, then init_done=1. Word load at 0x3FC → rsp_rdata=0x00000000, rsp_err=0.
- Store/load word: store word 0xDEADBEEF at 0x10, then load word at 0x10 → rsp_rdata=0xDEADBEEF; rsp_valid exactly 1 cycle after accept.
- Sub-word loads on the word stored at 0x10:
  - Byte load at 0x13, signed → 0xFFFFFFDE; unsigned → 0x000000DE.
  - Halfword load at 0x12, signed → 0xFFFFDEAD.
  - Byte load at 0x10, signed → 0xFFFFFFEF.
- Partial store: store half 0x1234 at 0x12, then store byte 0x55 at 0x10, then load word at 0x10 → 0x1234BE55.
- Errors and aliasing:
  - Word store at 0x11, size=11 → rsp_err=1, rsp_rdata=0.
  - Subsequent load word at 0x10 is unchanged.
  - Load word at 0x1010 aliases 0x10.
- Back-pressure and reset:
  - Hold rsp_ready=0 for 3 cycles → rsp_valid and rsp_rdata stable and req_ready=0; accept on the 4th cycle.
  - Assert reset while in RESP → rsp_valid=0 the next cycle; after re-init, load word at 0x10 returns 0.
